serial_bit_source: RTL

- Parallel-to-serial stage directly upstream of the team's Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x, the detector's serial input.
- A one-word holding register lets back-to-back words stream with no idle gap between them.
- x_valid marks cycles that carry real data.

---
 rtl/serial_bit_source.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder for the sequence detector: first bit on x one cycle after accept, then 1 bit/clk.
// Backpressure: one-word holding register; din_ready drops only while it is full.
module serial_bit_source #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic             x_q;
  logic             x_valid_q;
  logic             word_start_q;
  logic             en_q;

  logic             accept;
  logic             load_from_hold;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] load_ord;

  // Shift register always drains from bit 0, so reorder the word once at load time.
  function automatic logic [WIDTH-1:0] order_bits(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r[i] = w[int'(WIDTH) - 1 - i];
      end
    end
    return r;
  endfunction

  // en_q keeps din_ready low during reset and for the first cycle after release.
  assign din_ready      = en_q & ~hold_full_q;
  assign accept         = din_valid & din_ready;
  assign load_from_hold = (state_q == S_SHIFT) && (cnt_q == '0) && hold_full_q;
  assign load_word      = load_from_hold ? hold_q : din;
  assign load_ord       = order_bits(load_word);

  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign word_start = word_start_q;
  assign busy       = (state_q == S_SHIFT) | hold_full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      x_q          <= IDLE_BIT;
      x_valid_q    <= 1'b0;
      word_start_q <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      en_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q      <= S_SHIFT;
            shift_q      <= load_ord >> 1;
            x_q          <= load_ord[0];
            x_valid_q    <= 1'b1;
            word_start_q <= 1'b1;
            cnt_q        <= LAST_CNT;
          end else begin
            x_q          <= IDLE_BIT;
            x_valid_q    <= 1'b0;
            word_start_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            x_q          <= shift_q[0];
            shift_q      <= shift_q >> 1;
            cnt_q        <= cnt_q - 1'b1;
            word_start_q <= 1'b0;
            if (accept) begin
              hold_q      <= din;
              hold_full_q <= 1'b1;
            end
          end else if (hold_full_q || accept) begin
            // Last bit on x: chain the next word with no gap, held word first.
            shift_q      <= load_ord >> 1;
            x_q          <= load_ord[0];
            x_valid_q    <= 1'b1;
            word_start_q <= 1'b1;
            cnt_q        <= LAST_CNT;
            hold_full_q  <= 1'b0;
          end else begin
            state_q      <= S_IDLE;
            x_q          <= IDLE_BIT;
            x_valid_q    <= 1'b0;
            word_start_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
